lsu_stage: RTL and testbench
============================

# lsu_stage

Load/store execution stage fed directly by the issue stage's LSU dispatch port. It accepts one load or store per transaction and computes the effective address. It runs a single-outstanding request/acknowledge transaction on the data-memory port and formats load data into a write-back/forwarding result. It back-pressures issue with `o_stall` for the whole transaction and flags misaligned, illegal-size and timed-out accesses.

## Interface
- `ACK_TIMEOUT`, default 255: cycles `o_dmem_req` may stay high without `i_dmem_ack` before a bus-timeout exception; legal range 1..65535.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `i_flush` in 1: pipeline flush.
- `i_valid` in 1: issue presents an LSU op this cycle.
- `i_is_store` in 1: 1 = store, 0 = load.
- `i_funct3` in 3: RV32I size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `i_rd` in 5: load destination register.
- `i_imm` in 32: sign-extended offset.
- `i_addr_base` in 32: forwarded rs1.
- `i_store_data` in 32: forwarded rs2.
- `i_pc` in 32: PC of the op.
- `o_stall` out 1: back-pressure to issue.
- `o_dmem_req` out 1: memory request.
- `o_dmem_we` out 1: write enable.
- `o_dmem_addr` out 32: word-aligned address, {ea[31:2],2'b00}.
- `o_dmem_be` out 4: byte enables.
- `o_dmem_wdata` out 32: lane-replicated store data.
- `i_dmem_ack` in 1: request accepted/completed.
- `i_dmem_rdata` in 32: read word, valid with ack.
- `o_wb_valid` out 1: load result valid (1-cycle pulse).
- `o_wb_rd` out 5: result destination.
- `o_wb_data` out 32: formatted load data.
- `o_fwd_valid` out 1: `o_wb_valid && o_wb_rd != 0`.
- `o_exc_valid` out 1: exception pulse.
- `o_exc_cause` out 2: 0 misaligned, 1 bus timeout, 2 illegal size.
- `o_exc_pc` out 32: PC of the faulting op.
- `o_exc_addr` out 32: effective address of the faulting op.

## Operation
- States: IDLE, REQ, RESP, EXC.
- IDLE: on `i_valid && !i_flush`, latch op fields and `ea = i_addr_base + i_imm` (mod 2^32).
  - Illegal size (load funct3 3/6/7, store funct3 >= 3) -> EXC with cause 2.
  - Else misaligned (H/HU with ea[0]=1, W with ea[1:0]!=0) -> EXC with cause 0.
  - Else -> REQ.
- REQ: `o_dmem_req=1`; addr/be/wdata/we stable until ack.
  - Timeout counter clears on entry and increments each REQ cycle without ack.
  - Ack -> RESP for loads, IDLE for stores.
  - Counter reaching `ACK_TIMEOUT` without ack -> EXC with cause 1; req drops.
- Store lanes:
  - SB: be = 4'b0001<<ea[1:0], wdata = {4{data[7:0]}}.
  - SH: be = 4'b0011<<ea[1:0], wdata = {2{data[15:0]}}.
  - SW: be = 4'hF, wdata = data.
- Load formatting: read data is captured at ack. Select byte/half at ea[1:0]; zero-extend for BU/HU, sign-extend for B/H. Loads drive be per size as for stores.
- RESP: `o_wb_valid=1` for exactly one cycle, then -> IDLE.
- EXC: `o_exc_valid=1` for one cycle with cause/pc/addr; no memory request, no write-back; then -> IDLE.
- Flush:
  - In IDLE: `i_valid` is ignored.
  - In REQ: a store still completes. A load's transaction completes, but its result is discarded (no `o_wb_valid`).
  - In RESP or EXC: the pulse is suppressed.
  - Flush never cancels a raised `o_dmem_req` before ack.
- `o_stall = (state != IDLE)`.

## Timing
- Reset: state IDLE, counter 0. All outputs are 0: `o_stall`, `o_dmem_*`, `o_wb_*`, `o_fwd_valid`, `o_exc_*`.
- Reset mid-transaction returns to IDLE next edge and drops req immediately after that edge.
- Op accepted at edge N (IDLE, `i_valid`). REQ occupies cycle N+1 onward.
- Ack is taken in the same cycle req is high. Zero-wait memory: ack in N+1 -> load `o_wb_valid` in N+2, IDLE in N+3; store IDLE in N+2.
- Load-to-result latency is 2 + wait cycles. Throughput is one op per 3 cycles for loads and one per 2 for stores.
- `o_stall` is low in the accept cycle and high from N+1 until state returns to IDLE. Issue holds its next uop meanwhile.
- An exception pulse occurs at N+1; IDLE at N+2.
- Timeout: ack never arrives -> `o_exc_valid` exactly `ACK_TIMEOUT`+1 cycles after REQ entry.
- A late ack arriving in IDLE is ignored.

## Test plan
- LW, base 0x1000, imm 0x4, rdata 0xDEADBEEF ack in N+1 -> addr 0x1004, be 4'hF, `o_wb_valid` at N+2, rd data 0xDEADBEEF, `o_fwd_valid`=1 if rd!=0.
- LB at ea 0x1003 with rdata 0x80112233 -> be 4'b1000, data 0xFFFFFF80. Same op as LBU -> 0x00000080.
- SH at ea 0x2002, data 0x0000ABCD -> be 4'b1100, wdata 0xABCDABCD, we=1, no `o_wb_valid`, IDLE the cycle after ack.
- LW at ea 0x1006 -> no req, `o_exc_valid` cause 0, exc_addr 0x1006, correct pc.
- `ACK_TIMEOUT`=4, ack held low -> cause-1 exception after 5 REQ cycles, req then low. Load funct3=3 -> cause 2.
- Load with 3 wait states, `i_flush` pulsed during REQ -> req held until ack, no `o_wb_valid`. Mid-REQ `rst` -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lsu_stage_if.sv
// Data-memory port of the load/store stage: single-outstanding req/ack bus.
interface lsu_stage_if;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;

    modport master (
        output o_dmem_req,
        output o_dmem_we,
        output o_dmem_addr,
        output o_dmem_be,
        output o_dmem_wdata,
        input  i_dmem_ack,
        input  i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req,
        input  o_dmem_we,
        input  o_dmem_addr,
        input  o_dmem_be,
        input  o_dmem_wdata,
        output i_dmem_ack,
        output i_dmem_rdata
    );
endinterface

// File: rtl/lsu_stage.sv
// Load/store execution stage: effective-address generation, one outstanding
// data-memory transaction, load-data formatting and LSU exception reporting.
module lsu_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_valid,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_addr_base,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_pc,
    output logic        o_stall,
    lsu_stage_if.master dmem,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_fwd_valid,
    output logic        o_exc_valid,
    output logic [1:0]  o_exc_cause,
    output logic [31:0] o_exc_pc,
    output logic [31:0] o_exc_addr
);

    localparam logic [15:0] TIMEOUT = 16'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        EXC
    } state_t;

    state_t      state_q, state_d;
    logic        accept;

    logic        st_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] ea_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [15:0] cnt_q;
    logic        discard_q;
    logic [1:0]  cause_q;
    logic [31:0] ld_data_q;

    logic [31:0] ea;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    load_format = {{24{b[7]}}, b};
            3'd4:    load_format = {24'h0, b};
            3'd1:    load_format = {{16{h[15]}}, h};
            3'd5:    load_format = {16'h0, h};
            default: load_format = word;
        endcase
    endfunction

    // Decode of the op presented by issue: address, legality, lanes.
    always_comb begin
        ea = i_addr_base + i_imm;
        if (i_is_store) illegal = (i_funct3 >= 3'd3);
        else            illegal = (i_funct3 == 3'd3) || (i_funct3 == 3'd6) || (i_funct3 == 3'd7);
        misaligned = ((i_funct3[1:0] == 2'b01) && ea[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
        case (i_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ea[1:0];
                wdata_d = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << ea[1:0];
                wdata_d = {2{i_store_data[15:0]}};
            end
            default: begin
                be_d    = 4'hF;
                wdata_d = i_store_data;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and output decode; all outputs are gated to zero outside
    // the state that owns them so reset and idle present an all-zero port.
    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        o_stall           = (state_q != IDLE);
        dmem.o_dmem_req   = 1'b0;
        dmem.o_dmem_we    = 1'b0;
        dmem.o_dmem_addr  = '0;
        dmem.o_dmem_be    = '0;
        dmem.o_dmem_wdata = '0;
        o_wb_valid        = 1'b0;
        o_exc_valid       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && !i_flush) begin
                    accept  = 1'b1;
                    state_d = (illegal || misaligned) ? EXC : REQ;
                end
            end
            REQ: begin
                dmem.o_dmem_req   = 1'b1;
                dmem.o_dmem_we    = st_q;
                dmem.o_dmem_addr  = {ea_q[31:2], 2'b00};
                dmem.o_dmem_be    = be_q;
                dmem.o_dmem_wdata = wdata_q;
                if (dmem.i_dmem_ack)      state_d = st_q ? IDLE : RESP;
                else if (cnt_q == TIMEOUT) state_d = EXC;
            end
            RESP: begin
                o_wb_valid = !discard_q && !i_flush;
                state_d    = IDLE;
            end
            EXC: begin
                // A flushed op that later times out is squashed as well.
                o_exc_valid = !discard_q && !i_flush;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        o_wb_rd     = o_wb_valid ? rd_q : '0;
        o_wb_data   = o_wb_valid ? ld_data_q : '0;
        o_fwd_valid = o_wb_valid && (rd_q != 5'd0);
        o_exc_cause = o_exc_valid ? cause_q : '0;
        o_exc_pc    = o_exc_valid ? pc_q : '0;
        o_exc_addr  = o_exc_valid ? ea_q : '0;
    end

    // Op capture at accept, timeout counting, flush tracking and load capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= 1'b0;
            f3_q      <= '0;
            rd_q      <= '0;
            ea_q      <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            cause_q   <= '0;
            ld_data_q <= '0;
        end else begin
            if (accept) begin
                st_q      <= i_is_store;
                f3_q      <= i_funct3;
                rd_q      <= i_rd;
                ea_q      <= ea;
                be_q      <= be_d;
                wdata_q   <= wdata_d;
                pc_q      <= i_pc;
                cnt_q     <= '0;
                discard_q <= 1'b0;
                cause_q   <= illegal ? 2'd2 : 2'd0;
            end
            if (state_q == REQ) begin
                if (i_flush) discard_q <= 1'b1;
                if (dmem.i_dmem_ack) begin
                    ld_data_q <= load_format(f3_q, ea_q[1:0], dmem.i_dmem_rdata);
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == TIMEOUT) cause_q <= 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: vector table plus hand-written
// sequences, with a scoreboard queue checked by a negedge monitor.
module tb_lsu_stage;

    localparam int K_LD = 0;
    localparam int K_ST = 1;
    localparam int K_EX = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic        i_valid;
    logic        i_is_store;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd;
    logic [31:0] i_imm;
    logic [31:0] i_addr_base;
    logic [31:0] i_store_data;
    logic [31:0] i_pc;
    logic        o_stall;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_fwd_valid;
    logic        o_exc_valid;
    logic [1:0]  o_exc_cause;
    logic [31:0] o_exc_pc;
    logic [31:0] o_exc_addr;

    lsu_stage_if dmem ();

    lsu_stage #(.ACK_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .i_is_store  (i_is_store),
        .i_funct3    (i_funct3),
        .i_rd        (i_rd),
        .i_imm       (i_imm),
        .i_addr_base (i_addr_base),
        .i_store_data(i_store_data),
        .i_pc        (i_pc),
        .o_stall     (o_stall),
        .dmem        (dmem),
        .o_wb_valid  (o_wb_valid),
        .o_wb_rd     (o_wb_rd),
        .o_wb_data   (o_wb_data),
        .o_fwd_valid (o_fwd_valid),
        .o_exc_valid (o_exc_valid),
        .o_exc_cause (o_exc_cause),
        .o_exc_pc    (o_exc_pc),
        .o_exc_addr  (o_exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] base;
        logic [31:0] imm;
        logic [31:0] sdata;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          waits;
        int          kind;
        logic [31:0] addr;   // word address for requests, ea for exceptions
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [1:0]  cause;
    } vec_t;

    typedef struct {
        int          kind;
        logic        discard;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        fwd;
        logic [1:0]  cause;
        logic [31:0] pc;
        logic [31:0] eaddr;
    } exp_t;

    exp_t q[$];
    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] base, input logic [31:0] imm,
                                input logic [31:0] sdata, input logic [31:0] pc,
                                input logic [31:0] rdata, input int waits, input int kind,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] data,
                                input logic [1:0] cause);
        vec_t v;
        v.st = st; v.f3 = f3; v.rd = rd; v.base = base; v.imm = imm; v.sdata = sdata;
        v.pc = pc; v.rdata = rdata; v.waits = waits; v.kind = kind; v.addr = addr;
        v.be = be; v.wdata = wdata; v.data = data; v.cause = cause;
        return v;
    endfunction

    task automatic drive_op(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] base, input logic [31:0] imm,
                            input logic [31:0] sdata, input logic [31:0] pc);
        i_valid = 1'b1; i_is_store = st; i_funct3 = f3; i_rd = rd;
        i_addr_base = base; i_imm = imm; i_store_data = sdata; i_pc = pc;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"},   32'(o_stall), 32'd0);
        chk({tag, "_req"},     32'(dmem.o_dmem_req), 32'd0);
        chk({tag, "_we"},      32'(dmem.o_dmem_we), 32'd0);
        chk({tag, "_addr"},    dmem.o_dmem_addr, 32'd0);
        chk({tag, "_be"},      32'(dmem.o_dmem_be), 32'd0);
        chk({tag, "_wdata"},   dmem.o_dmem_wdata, 32'd0);
        chk({tag, "_wbv"},     32'(o_wb_valid), 32'd0);
        chk({tag, "_wbrd"},    32'(o_wb_rd), 32'd0);
        chk({tag, "_wbdata"},  o_wb_data, 32'd0);
        chk({tag, "_fwd"},     32'(o_fwd_valid), 32'd0);
        chk({tag, "_excv"},    32'(o_exc_valid), 32'd0);
        chk({tag, "_cause"},   32'(o_exc_cause), 32'd0);
        chk({tag, "_excpc"},   o_exc_pc, 32'd0);
        chk({tag, "_excaddr"}, o_exc_addr, 32'd0);
    endtask

    // Scoreboard monitor: request fields every req cycle, results on pulses.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (dmem.o_dmem_req) begin
                if (q.size() == 0) begin
                    chk("req_with_no_op", 32'(q.size()), 32'd1);
                end else begin
                    chk("req_addr", dmem.o_dmem_addr, q[0].addr);
                    chk("req_be", 32'(dmem.o_dmem_be), 32'(q[0].be));
                    chk("req_we", 32'(dmem.o_dmem_we), 32'(q[0].we));
                    if (q[0].we) chk("req_wdata", dmem.o_dmem_wdata, q[0].wdata);
                    if (dmem.i_dmem_ack && (q[0].kind == K_ST || q[0].discard)) void'(q.pop_front());
                end
            end
            if (o_wb_valid) begin
                if (q.size() == 0) begin
                    chk("wb_with_no_op", 32'(q.size()), 32'd1);
                end else begin
                    chk("wb_kind", 32'(K_LD), 32'(q[0].kind));
                    chk("wb_rd", 32'(o_wb_rd), 32'(q[0].rd));
                    chk("wb_data", o_wb_data, q[0].data);
                    chk("wb_fwd", 32'(o_fwd_valid), 32'(q[0].fwd));
                    void'(q.pop_front());
                end
            end
            if (o_exc_valid) begin
                if (q.size() == 0) begin
                    chk("exc_with_no_op", 32'(q.size()), 32'd1);
                end else begin
                    chk("exc_kind", 32'(K_EX), 32'(q[0].kind));
                    chk("exc_cause", 32'(o_exc_cause), 32'(q[0].cause));
                    chk("exc_pc", o_exc_pc, q[0].pc);
                    chk("exc_addr", o_exc_addr, q[0].eaddr);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        e.kind = v.kind; e.discard = 1'b0; e.addr = v.addr; e.be = v.be; e.we = v.st;
        e.wdata = v.wdata; e.rd = v.rd; e.data = v.data; e.fwd = (v.rd != 5'd0);
        e.cause = v.cause; e.pc = v.pc; e.eaddr = v.addr;
        q.push_back(e);
        step();
        drive_op(v.st, v.f3, v.rd, v.base, v.imm, v.sdata, v.pc);
        smp();
        chk("stall_accept", 32'(o_stall), 32'd0);
        if (v.kind == K_EX) begin
            step();
            i_valid = 1'b0;
            smp();
            chk("exc_pulse", 32'(o_exc_valid), 32'd1);
            chk("exc_noreq", 32'(dmem.o_dmem_req), 32'd0);
            chk("exc_stall", 32'(o_stall), 32'd1);
            step();
            smp();
            chk("exc_idle", 32'(o_stall), 32'd0);
            chk("exc_once", 32'(o_exc_valid), 32'd0);
        end else begin
            for (int w = 0; w <= v.waits; w++) begin
                step();
                i_valid = 1'b0;
                dmem.i_dmem_ack = (w == v.waits);
                dmem.i_dmem_rdata = (w == v.waits) ? v.rdata : $urandom;
                smp();
                chk("req_high", 32'(dmem.o_dmem_req), 32'd1);
                chk("req_stall", 32'(o_stall), 32'd1);
            end
            step();
            dmem.i_dmem_ack = 1'b0;
            dmem.i_dmem_rdata = $urandom;
            smp();
            if (v.kind == K_LD) begin
                chk("ld_wb_pulse", 32'(o_wb_valid), 32'd1);
                chk("ld_resp_stall", 32'(o_stall), 32'd1);
                step();
                smp();
                chk("ld_idle", 32'(o_stall), 32'd0);
                chk("ld_wb_once", 32'(o_wb_valid), 32'd0);
            end else begin
                chk("st_idle", 32'(o_stall), 32'd0);
                chk("st_no_wb", 32'(o_wb_valid), 32'd0);
                chk("st_req_drop", 32'(dmem.o_dmem_req), 32'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_is_store = 1'b0; i_funct3 = '0;
        i_rd = '0; i_imm = '0; i_addr_base = '0; i_store_data = '0; i_pc = '0;
        dmem.i_dmem_ack = 1'b0; dmem.i_dmem_rdata = '0;

        //             st  f3 rd  base          imm           sdata         pc            rdata        w  kind  addr          be       wdata         data          cause
        vecs[0]  = mk(0, 2, 5,  32'h0000_1000, 32'h0000_0004, 32'h0,        32'h0000_0100, 32'hDEADBEEF, 0, K_LD, 32'h0000_1004, 4'hF,    32'h0,        32'hDEADBEEF, 2'd0);
        vecs[1]  = mk(0, 0, 7,  32'h0000_1000, 32'h0000_0003, 32'h0,        32'h0000_0104, 32'h80112233, 0, K_LD, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFFFF80, 2'd0);
        vecs[2]  = mk(0, 4, 0,  32'h0000_1000, 32'h0000_0003, 32'h0,        32'h0000_0108, 32'h80112233, 1, K_LD, 32'h0000_1000, 4'b1000, 32'h0,        32'h00000080, 2'd0);
        vecs[3]  = mk(1, 1, 0,  32'h0000_2000, 32'h0000_0002, 32'h0000ABCD, 32'h0000_010C, 32'h0,        1, K_ST, 32'h0000_2000, 4'b1100, 32'hABCDABCD, 32'h0,        2'd0);
        vecs[4]  = mk(0, 2, 9,  32'h0000_1000, 32'h0000_0006, 32'h0,        32'h0000_0080, 32'h0,        0, K_EX, 32'h0000_1006, 4'h0,    32'h0,        32'h0,        2'd0);
        vecs[5]  = mk(0, 3, 9,  32'h0000_3000, 32'h0000_0010, 32'h0,        32'h0000_0084, 32'h0,        0, K_EX, 32'h0000_3010, 4'h0,    32'h0,        32'h0,        2'd2);
        vecs[6]  = mk(0, 1, 12, 32'h0000_1000, 32'h0000_0002, 32'h0,        32'h0000_0110, 32'h80017FFF, 2, K_LD, 32'h0000_1000, 4'b1100, 32'h0,        32'hFFFF8001, 2'd0);
        vecs[7]  = mk(0, 5, 13, 32'h0000_1000, 32'h0000_0000, 32'h0,        32'h0000_0114, 32'h1234F00D, 0, K_LD, 32'h0000_1000, 4'b0011, 32'h0,        32'h0000F00D, 2'd0);
        vecs[8]  = mk(1, 0, 0,  32'h0000_2000, 32'h0000_0001, 32'h000000A5, 32'h0000_0118, 32'h0,        0, K_ST, 32'h0000_2000, 4'b0010, 32'hA5A5A5A5, 32'h0,        2'd0);
        vecs[9]  = mk(1, 2, 0,  32'h0000_2010, 32'hFFFF_FFF4, 32'h12345678, 32'h0000_011C, 32'h0,        3, K_ST, 32'h0000_2004, 4'hF,    32'h12345678, 32'h0,        2'd0);
        vecs[10] = mk(1, 3, 0,  32'h0000_2000, 32'h0000_0000, 32'h11111111, 32'h0000_0120, 32'h0,        0, K_EX, 32'h0000_2000, 4'h0,    32'h0,        32'h0,        2'd2);
        vecs[11] = mk(0, 1, 4,  32'h0000_1000, 32'h0000_0001, 32'h0,        32'h0000_0124, 32'h0,        0, K_EX, 32'h0000_1001, 4'h0,    32'h0,        32'h0,        2'd0);
        vecs[12] = mk(0, 0, 31, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,        32'h0000_0128, 32'h7F000000, 0, K_LD, 32'hFFFF_FFFC, 4'b1000, 32'h0,        32'h0000007F, 2'd0);

        step();
        step();
        smp();
        check_all_zero("reset");
        step();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Ack never arrives: five REQ cycles, then a cause-1 exception.
        e = '{kind: K_EX, discard: 1'b0, addr: 32'h0000_4000, be: 4'hF, we: 1'b0, wdata: 32'h0,
              rd: 5'd2, data: 32'h0, fwd: 1'b0, cause: 2'd1, pc: 32'h0000_0200, eaddr: 32'h0000_4000};
        q.push_back(e);
        step();
        drive_op(1'b0, 3'd2, 5'd2, 32'h0000_4000, 32'h0, 32'h0, 32'h0000_0200);
        for (int i = 0; i < 5; i++) begin
            step();
            i_valid = 1'b0;
            smp();
            chk("to_req_high", 32'(dmem.o_dmem_req), 32'd1);
        end
        step();
        smp();
        chk("to_exc_pulse", 32'(o_exc_valid), 32'd1);
        chk("to_req_low", 32'(dmem.o_dmem_req), 32'd0);
        step();
        smp();
        chk("to_idle", 32'(o_stall), 32'd0);

        // Late ack while idle is ignored.
        step();
        dmem.i_dmem_ack = 1'b1;
        dmem.i_dmem_rdata = 32'hCAFEF00D;
        smp();
        chk("late_ack_stall", 32'(o_stall), 32'd0);
        step();
        dmem.i_dmem_ack = 1'b0;
        smp();
        chk("late_ack_nowb", 32'(o_wb_valid), 32'd0);
        chk("late_ack_stall2", 32'(o_stall), 32'd0);

        // Flush in IDLE blocks acceptance.
        step();
        drive_op(1'b0, 3'd2, 5'd3, 32'h0000_1000, 32'h0, 32'h0, 32'h0000_0300);
        i_flush = 1'b1;
        step();
        i_valid = 1'b0;
        i_flush = 1'b0;
        smp();
        chk("idle_flush_stall", 32'(o_stall), 32'd0);
        chk("idle_flush_req", 32'(dmem.o_dmem_req), 32'd0);

        // Flush during a 3-wait load: req held to ack, result dropped.
        e = '{kind: K_LD, discard: 1'b1, addr: 32'h0000_1008, be: 4'hF, we: 1'b0, wdata: 32'h0,
              rd: 5'd3, data: 32'h0, fwd: 1'b0, cause: 2'd0, pc: 32'h0000_0304, eaddr: 32'h0000_1008};
        q.push_back(e);
        step();
        drive_op(1'b0, 3'd2, 5'd3, 32'h0000_1008, 32'h0, 32'h0, 32'h0000_0304);
        for (int w = 0; w <= 3; w++) begin
            step();
            i_valid = 1'b0;
            i_flush = (w == 1);
            dmem.i_dmem_ack = (w == 3);
            dmem.i_dmem_rdata = 32'h55AA55AA;
            smp();
            chk("flush_req_hold", 32'(dmem.o_dmem_req), 32'd1);
        end
        step();
        dmem.i_dmem_ack = 1'b0;
        i_flush = 1'b0;
        smp();
        chk("flush_no_wb", 32'(o_wb_valid), 32'd0);
        chk("flush_resp_stall", 32'(o_stall), 32'd1);
        step();
        smp();
        chk("flush_idle", 32'(o_stall), 32'd0);

        // Reset in the middle of REQ.
        e = '{kind: K_LD, discard: 1'b0, addr: 32'h0000_1000, be: 4'hF, we: 1'b0, wdata: 32'h0,
              rd: 5'd6, data: 32'h0, fwd: 1'b1, cause: 2'd0, pc: 32'h0000_0400, eaddr: 32'h0000_1000};
        q.push_back(e);
        step();
        drive_op(1'b0, 3'd2, 5'd6, 32'h0000_1000, 32'h0, 32'h0, 32'h0000_0400);
        step();
        i_valid = 1'b0;
        smp();
        chk("rst_mid_req", 32'(dmem.o_dmem_req), 32'd1);
        step();
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        smp();
        check_all_zero("midreq_rst");

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
